// File: rtl/corescore_stream_fifo.sv
// Synchronous FIFO with a separately tracked occupancy count; pointers wrap modulo depth.
// Push is ignored when full and pop is ignored when empty, so the level never over- or under-flows.
module corescore_stream_fifo #(
    parameter int width = 9,
    parameter int aw    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [width-1:0] i_data,
    input  logic             i_pop,
    output logic [width-1:0] o_data,
    output logic [aw:0]      o_level,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << aw;
    typedef logic [aw:0]   lvl_t;
    typedef logic [aw-1:0] ptr_t;

    logic [width-1:0] mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    lvl_t level_q, level_d;
    logic push_ok, pop_ok;

    assign o_full  = (level_q == lvl_t'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = i_push && !o_full;
        pop_ok   = i_pop && !o_empty;
        wr_ptr_d = wr_ptr_q + ptr_t'(push_ok);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_ok);
        level_d  = level_q + lvl_t'(push_ok) - lvl_t'(pop_ok);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end
endmodule

// File: rtl/corescore_emitter_uart_buf.sv
// Buffered 8N1 UART emitter for the corescore byte stream, with optional CR LF after each
// message-final byte. Frames run back to back whenever there is something left to send.
module corescore_emitter_uart_buf #(
    parameter int clk_freq_hz     = 12_500_000,
    parameter int baud_rate       = 57600,
    parameter int fifo_aw         = 4,
    parameter int newline_on_last = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_data,
    input  logic             i_last,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_uart_tx,
    output logic [fifo_aw:0] o_level,
    output logic             o_busy
);
    localparam int         DIV        = clk_freq_hz / baud_rate;
    localparam int         CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int         FRAME_BITS = 10;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam bit         NL_EN      = (newline_on_last != 0);

    generate
        if (DIV < 2) begin : g_div_check
            $error("corescore_emitter_uart_buf: clk_freq_hz / baud_rate must be at least 2");
        end
    endgenerate

    typedef logic [CNT_W-1:0] baud_t;
    localparam baud_t      BAUD_LAST = baud_t'(DIV - 1);
    localparam logic [3:0] BIT_LAST  = 4'(FRAME_BITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CR, ST_LF} state_t;

    state_t      state_q, state_d;
    logic [9:0]  shreg_q, shreg_d;
    baud_t       baud_q, baud_d;
    logic [3:0]  bit_q, bit_d;
    logic        last_q, last_d;
    logic        tx_q, tx_d;
    logic        run_q;
    logic        push, pop, load;
    logic [7:0]  load_byte;
    logic [8:0]  fifo_rd;
    logic        fifo_full, fifo_empty;
    logic [fifo_aw:0] fifo_level;

    corescore_stream_fifo #(
        .width (9),
        .aw    (fifo_aw)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_data  ({i_last, i_data}),
        .i_pop   (pop),
        .o_data  (fifo_rd),
        .o_level (fifo_level),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // run_q holds o_ready low during reset even though the cleared level reads as empty.
    assign o_ready   = run_q && !fifo_full;
    assign push      = i_valid && o_ready;
    assign o_uart_tx = tx_q;
    assign o_level   = fifo_level;
    assign o_busy    = (state_q != ST_IDLE) || (fifo_level != '0);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        last_d    = last_q;
        pop       = 1'b0;
        load      = 1'b0;
        load_byte = fifo_rd[7:0];
        tx_d      = (state_q == ST_IDLE) ? 1'b1 : shreg_q[0];

        if (state_q == ST_IDLE) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                load    = 1'b1;
                last_d  = fifo_rd[8];
                state_d = ST_DATA;
            end
        end else if (baud_q != BAUD_LAST) begin
            baud_d = baud_q + 1'b1;
        end else if (bit_q != BIT_LAST) begin
            baud_d  = '0;
            bit_d   = bit_q + 4'd1;
            shreg_d = {1'b1, shreg_q[9:1]};
        end else if (state_q == ST_CR) begin
            load      = 1'b1;
            load_byte = LF;
            state_d   = ST_LF;
        end else if (state_q == ST_DATA && last_q && NL_EN) begin
            load      = 1'b1;
            load_byte = CR;
            state_d   = ST_CR;
        end else if (!fifo_empty) begin
            // Chain straight into the next queued byte so the stop bit is followed by a start bit.
            pop     = 1'b1;
            load    = 1'b1;
            last_d  = fifo_rd[8];
            state_d = ST_DATA;
        end else begin
            state_d = ST_IDLE;
        end

        if (load) begin
            shreg_d = {1'b1, load_byte, 1'b0};
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            tx_q    <= 1'b1;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            run_q   <= 1'b1;
        end
    end
endmodule
